vdec1_crc_chk: RTL
==================

# vdec1_crc_chk

Sequencer for the serial CRC step logic in the vdec1 decoder back end. It accepts one decoded hard bit per cycle through a valid/ready handshake and steps the selected CRC register (8/12/16/24-bit) once per accepted bit. It counts the block length, including the appended CRC bits, and at end of block reports a pass/fail verdict plus the final remainder. It sits between the decoder bit output and the block-status/HARQ logic and is the only owner of the CRC state register.

## Interface
Parameters:
- LEN_W, 13: width of block-length field (max 8191 bits incl. CRC)

Ports:
- clk  in  1  decoder clock, 307.2 MHz
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches cfg_sel/cfg_len; honoured only in IDLE
- abort  in  1  one-cycle pulse; returns to IDLE from any state, no done
- cfg_sel  in  2  CRC type: 0=CRC8, 1=CRC12, 2=CRC16, 3=CRC24
- cfg_len  in  LEN_W  total bits in block = payload + CRC length
- bit_vld  in  1  bit_in valid
- bit_in  in  1  decoded bit, MSB-first, payload then CRC
- bit_rdy  out  1  ready; a bit is consumed when bit_vld & bit_rdy
- busy  out  1  high in RUN
- done  out  1  one-cycle end-of-block pulse
- crc_ok  out  1  verdict, valid from done, held until next accepted start
- len_err  out  1  cfg_len illegal, valid from done, held like crc_ok
- crc_rem  out  24  final remainder, zero-extended above the CRC length, held like crc_ok

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start: latch sel/len; clear crc_reg to 0; clear bit counter; clear crc_ok, len_err, crc_rem.
  - Legal length (cfg_len > CRC length of cfg_sel: 8/12/16/24) -> RUN.
  - Otherwise -> DONE with len_err=1, crc_ok=0, crc_rem=0; no bits consumed.
- RUN:
  - bit_rdy=1.
  - Each handshake: crc_reg <= step(crc_reg, bit_in, sel) and counter += 1.
  - The 24-bit register holds all four widths; bits above the selected length are kept at 0.
  - step is feedback from the register MSB, input XORed into bit 0. Generator polynomials:
    - CRC8 0x19B
    - CRC12 0x180F
    - CRC16 0x11021
    - CRC24 0x1864CFB
  - When the handshake accepts bit number len (counter == len-1): -> DONE.
  - Verdict is taken from the post-step value: crc_rem <= that value, crc_ok <= (value == 0).
- DONE: done=1 for exactly one cycle, then -> IDLE.
- abort:
  - Has priority over start and over any bit handshake in the same cycle.
  - -> IDLE; crc_ok/len_err/crc_rem are cleared to 0; done is not asserted.
- start outside IDLE is ignored; it is not queued.
- bit_vld while bit_rdy=0 is not consumed. Upstream must hold the bit.
- Counter: LEN_W bits; it never wraps because the exit compare occurs at len-1.

## Timing
- Reset values: bit_rdy=0, busy=0, done=0, crc_ok=0, len_err=0, crc_rem=0; state=IDLE; crc_reg=0; counter=0.
- start at cycle T -> bit_rdy=1 and busy=1 at T+1.
- Last bit accepted at cycle L -> done, crc_ok and crc_rem valid at L+1; bit_rdy=0 at L+1.
- Illegal length: start at T -> done and len_err at T+1.
- Earliest next start: the cycle after done (IDLE). Minimum turnaround is len+2 cycles per block with continuous bit_vld.
- Gaps in bit_vld stall the block with no state change; there is no timeout.
- All outputs are registered; there is no combinational path from bit_vld/bit_in to any output.

## Test plan
- CRC8, len=9, bits 1,1,0,0,1,1,0,1,1 (payload "1" + 0x9B) -> done at L+1, crc_ok=1, crc_rem=0x000000.
- Same stream with the last bit flipped -> crc_ok=0, crc_rem=0x000001.
- CRC24, len=25, payload "1" + 0x864CFB MSB-first, with bit_vld deasserted on every 3rd cycle -> crc_ok=1, crc_rem=0; done exactly one cycle after the 25th handshake.
- CRC16, len=16 (equal to CRC length) -> done at T+1, len_err=1, crc_ok=0, zero bits consumed. Then start with CRC12, len=13, all-zero bits -> crc_ok=1.
- CRC16 block of 40 all-zero bits: start pulsed mid-block (ignored), then abort at bit 20 asserted together with bit_vld -> no done, that bit not counted, IDLE next cycle. A fresh block then completes with the correct verdict.
- rst asserted mid-RUN -> all outputs at reset values the next cycle; a subsequent CRC8 block passes.

Source files
------------

// File: rtl/vdec1_crc_chk.sv
// Serial CRC checker for the vdec1 back end: steps a shared 24-bit register once per
// accepted hard bit and reports the verdict and remainder at end of block.
module vdec1_crc_chk #(
  parameter int LEN_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       cfg_sel,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             bit_vld,
  input  logic             bit_in,
  output logic             bit_rdy,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic             len_err,
  output logic [23:0]      crc_rem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Generator polynomials without the implicit top term, indexed by cfg_sel.
  localparam logic [3:0][23:0] POLY_LO = {24'h864CFB, 24'h001021, 24'h00080F, 24'h00009B};

  state_t           state_reg;
  logic [1:0]       sel_reg;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] cnt_reg;
  logic [23:0]      crc_reg;
  logic             bit_rdy_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             crc_ok_reg;
  logic             len_err_reg;
  logic [23:0]      crc_rem_reg;

  logic [23:0]      step_val [4];
  logic [23:0]      step_next;
  logic             len_legal;
  logic             last_bit;

  function automatic logic [LEN_W-1:0] crc_len(input logic [1:0] s);
    case (s)
      2'd0:    return LEN_W'(8);
      2'd1:    return LEN_W'(12);
      2'd2:    return LEN_W'(16);
      default: return LEN_W'(24);
    endcase
  endfunction

  // One candidate step per CRC width; truncating the shift to W bits keeps the
  // bits above the selected length at zero.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_step
      localparam int W = (gi == 3) ? 24 : 8 + 4 * gi;
      logic [23:0] shifted;
      assign shifted      = 24'({crc_reg[W-2:0], bit_in});
      assign step_val[gi] = crc_reg[W-1] ? (shifted ^ POLY_LO[gi]) : shifted;
    end
  endgenerate

  assign step_next = step_val[sel_reg];
  assign len_legal = cfg_len > crc_len(cfg_sel);
  assign last_bit  = cnt_reg == (len_reg - LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      sel_reg     <= 2'd0;
      len_reg     <= '0;
      cnt_reg     <= '0;
      crc_reg     <= '0;
      bit_rdy_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      crc_ok_reg  <= 1'b0;
      len_err_reg <= 1'b0;
      crc_rem_reg <= '0;
    end else if (abort) begin
      // Abort wins over start and over a bit presented in the same cycle.
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      crc_reg     <= '0;
      bit_rdy_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      crc_ok_reg  <= 1'b0;
      len_err_reg <= 1'b0;
      crc_rem_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            sel_reg     <= cfg_sel;
            len_reg     <= cfg_len;
            cnt_reg     <= '0;
            crc_reg     <= '0;
            crc_ok_reg  <= 1'b0;
            crc_rem_reg <= '0;
            if (len_legal) begin
              state_reg   <= RUN;
              bit_rdy_reg <= 1'b1;
              busy_reg    <= 1'b1;
              len_err_reg <= 1'b0;
            end else begin
              state_reg   <= DONE;
              done_reg    <= 1'b1;
              len_err_reg <= 1'b1;
            end
          end
        end
        RUN: begin
          // bit_rdy is high throughout RUN, so bit_vld alone marks a handshake.
          if (bit_vld) begin
            crc_reg <= step_next;
            cnt_reg <= cnt_reg + LEN_W'(1);
            if (last_bit) begin
              state_reg   <= DONE;
              bit_rdy_reg <= 1'b0;
              busy_reg    <= 1'b0;
              done_reg    <= 1'b1;
              crc_rem_reg <= step_next;
              crc_ok_reg  <= (step_next == 24'd0);
            end
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg   <= IDLE;
          bit_rdy_reg <= 1'b0;
          busy_reg    <= 1'b0;
          done_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign bit_rdy = bit_rdy_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign crc_ok  = crc_ok_reg;
  assign len_err = len_err_reg;
  assign crc_rem = crc_rem_reg;

endmodule
